// File: rtl/dip_led_sequencer.sv
// DIP switch debouncer and LED pattern sequencer: 2-FF sync, shared-counter debounce,
// mode decode from sw[7:6], and a free-running step timer driving direct/blink/chase/count.
module dip_led_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_CYCLES     = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  output logic [7:0] led,
  output logic [7:0] sw_stable,
  output logic [1:0] mode,
  output logic       step_tick
);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_W = $clog2(STEP_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {M_DIRECT, M_BLINK, M_CHASE, M_COUNT} mode_e;

  logic [1:0][7:0]  sync_q, sync_d;
  logic [7:0]       cand_q, cand_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [7:0]       stable_q, stable_d;
  mode_e            mode_q, mode_d, new_mode;
  logic             mode_chg;
  logic [ST_W-1:0]  step_cnt_q, step_cnt_d;
  logic             tick_q, tick_d;
  logic             phase_q, phase_d;
  logic [7:0]       chase_q, chase_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       led_q, led_d;

  always_comb begin
    sync_d   = {sync_q[0], sw};
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    // Any movement of the synchronised vector restarts the single shared count.
    if (sync_q[1] != cand_q) begin
      cand_d   = sync_q[1];
      db_cnt_d = '0;
    end else if (db_cnt_q < DB_LAST) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end else begin
      stable_d = cand_q;
    end

    new_mode   = mode_e'(stable_q[7:6]);
    mode_chg   = (new_mode != mode_q);
    mode_d     = mode_q;
    step_cnt_d = step_cnt_q;
    phase_d    = phase_q;
    chase_d    = chase_q;
    count_d    = count_q;
    // A mode change reloads everything and takes priority over a pending step.
    if (mode_chg) begin
      mode_d     = new_mode;
      step_cnt_d = '0;
      phase_d    = 1'b1;
      chase_d    = 8'h01;
      count_d    = 8'h00;
    end else begin
      step_cnt_d = (step_cnt_q == ST_LAST) ? '0 : step_cnt_q + ST_W'(1);
      if (tick_q) begin
        case (mode_q)
          M_BLINK: phase_d = ~phase_q;
          M_CHASE: chase_d = {chase_q[6:0], chase_q[7]};
          M_COUNT: count_d = count_q + 8'd1;
          default: ;
        endcase
      end
    end
    tick_d = !mode_chg && (step_cnt_d == ST_LAST);

    case (mode_q)
      M_BLINK: led_d = phase_q ? {2'b00, stable_q[5:0]} : 8'h00;
      M_CHASE: led_d = chase_q;
      M_COUNT: led_d = count_q;
      default: led_d = stable_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      cand_q     <= '0;
      db_cnt_q   <= '0;
      stable_q   <= '0;
      mode_q     <= M_DIRECT;
      step_cnt_q <= '0;
      tick_q     <= 1'b0;
      phase_q    <= 1'b1;
      chase_q    <= 8'h01;
      count_q    <= 8'h00;
      led_q      <= 8'h00;
    end else begin
      sync_q     <= sync_d;
      cand_q     <= cand_d;
      db_cnt_q   <= db_cnt_d;
      stable_q   <= stable_d;
      mode_q     <= mode_d;
      step_cnt_q <= step_cnt_d;
      tick_q     <= tick_d;
      phase_q    <= phase_d;
      chase_q    <= chase_d;
      count_q    <= count_d;
      led_q      <= led_d;
    end
  end

  assign led       = led_q;
  assign sw_stable = stable_q;
  assign mode      = mode_q;
  assign step_tick = tick_q;
endmodule

// File: tb/tb_dip_led_sequencer.sv
// Bench for dip_led_sequencer: vector table, hand-written corner sequences and
// randomized switch activity, all checked each edge against a behavioural model.
module tb_dip_led_sequencer;
  localparam int DB = 4;
  localparam int ST = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [7:0] led, sw_stable;
  logic [1:0] mode;
  logic       step_tick;

  int vectors = 0;
  int miscompares = 0;

  dip_led_sequencer #(.DEBOUNCE_CYCLES(DB), .STEP_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .led(led),
    .sw_stable(sw_stable), .mode(mode), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  // Model: s_sync is the input two edges late; a value commits once it has been
  // seen DB+1 edges in a row; patterns are derived from ticks taken since the mode began.
  logic [7:0] m_sq[$];
  logic [7:0] m_win[$];
  logic [7:0] m_stable, m_led;
  logic [1:0] m_mode;
  logic       m_tick;
  int         m_cyc, m_k;

  task automatic model_reset();
    m_sq = {8'h00, 8'h00};
    m_win = {};
    for (int i = 0; i <= DB; i++) m_win.push_back(8'h00);
    m_stable = 8'h00; m_led = 8'h00; m_mode = 2'd0; m_tick = 1'b0;
    m_cyc = 0; m_k = 0;
  endtask

  function automatic logic [7:0] pattern(input logic [1:0] md, input logic [7:0] st, input int k);
    logic [7:0] one;
    one = 8'h01;
    case (md)
      2'd0:    return st;
      2'd1:    return (k % 2 == 0) ? {2'b00, st[5:0]} : 8'h00;
      2'd2:    return one << (k % 8);
      default: return 8'(k % 256);
    endcase
  endfunction

  task automatic model_edge(input logic [7:0] s);
    logic [7:0] ss, led_n;
    logic commit;
    ss = m_sq.pop_front();
    m_sq.push_back(s);
    m_win.push_back(ss);
    void'(m_win.pop_front());
    commit = 1'b1;
    foreach (m_win[i]) if (m_win[i] != ss) commit = 1'b0;
    led_n = pattern(m_mode, m_stable, m_k);
    if (m_stable[7:6] != m_mode) begin
      m_mode = m_stable[7:6]; m_cyc = 0; m_k = 0;
    end else begin
      if (m_tick) m_k++;
      m_cyc++;
    end
    m_tick = (m_cyc % ST) == ST - 1;
    if (commit) m_stable = ss;
    m_led = led_n;
  endtask

  task automatic check_model();
    vectors++;
    if (led !== m_led || sw_stable !== m_stable || mode !== m_mode || step_tick !== m_tick) begin
      miscompares++;
      $display("FAIL model @%0t: got led=%h sw_stable=%h mode=%0d tick=%b, want led=%h sw_stable=%h mode=%0d tick=%b",
               $time, led, sw_stable, mode, step_tick, m_led, m_stable, m_mode, m_tick);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_edge(sw);
    #1;
    check_model();
  endtask

  // Called just after an edge; asserts reset between edges and checks it bites at once.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 model_reset();
    chk("rst_led", led, 8'h00);
    chk("rst_sw_stable", sw_stable, 8'h00);
    chk("rst_mode", {6'b0, mode}, 8'h00);
    chk("rst_tick", {7'b0, step_tick}, 8'h00);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] sw;
    int         hold;
    logic [7:0] st;
    logic [1:0] md;
    logic [7:0] led;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] one;
    int t;
    one = 8'h01;
    tbl[0] = '{8'h00, 12, 8'h00, 2'd0, 8'h00};
    tbl[1] = '{8'h3C, 12, 8'h3C, 2'd0, 8'h3C};
    tbl[2] = '{8'h55, 12, 8'h55, 2'd1, 8'h15};
    tbl[3] = '{8'h95, 20, 8'h95, 2'd2, 8'h02};
    tbl[4] = '{8'hD5, 30, 8'hD5, 2'd3, 8'h02};
    tbl[5] = '{8'h15, 12, 8'h15, 2'd0, 8'h15};
    tbl[6] = '{8'h17, 10, 8'h17, 2'd0, 8'h17};
    tbl[7] = '{8'h1C,  6, 8'h17, 2'd0, 8'h17};
    tbl[8] = '{8'h1C,  1, 8'h1C, 2'd0, 8'h17};
    tbl[9] = '{8'h1C,  1, 8'h1C, 2'd0, 8'h1C};

    model_reset();
    #1;
    chk("init_led", led, 8'h00);
    chk("init_sw_stable", sw_stable, 8'h00);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      sw = tbl[i].sw;
      repeat (tbl[i].hold) clk_step();
      chk($sformatf("tbl%0d_sw_stable", i), sw_stable, tbl[i].st);
      chk($sformatf("tbl%0d_mode", i), {6'b0, mode}, {6'b0, tbl[i].md});
      chk($sformatf("tbl%0d_led", i), led, tbl[i].led);
    end

    // Mid-run reset with sw=3C, then release latency.
    sw = 8'hE7;
    repeat (20) clk_step();
    sw = 8'h3C;
    do_reset();
    repeat (6) clk_step();
    chk("rel6_sw_stable", sw_stable, 8'h00);
    clk_step();
    chk("rel7_sw_stable", sw_stable, 8'h3C);
    chk("rel7_led", led, 8'h00);
    clk_step();
    chk("rel8_led", led, 8'h3C);

    // Debounce filter: 3-cycle glitches never commit.
    sw = 8'h01;
    repeat (12) clk_step();
    for (int g = 0; g < 4; g++) begin
      sw = 8'h00; repeat (3) clk_step();
      sw = 8'h01; repeat (2) clk_step();
    end
    chk("glitch_sw_stable", sw_stable, 8'h01);
    sw = 8'h00;
    repeat (6) clk_step();
    chk("hold6_sw_stable", sw_stable, 8'h01);
    clk_step();
    chk("hold7_sw_stable", sw_stable, 8'h00);
    repeat (4) clk_step();

    // BLINK: led alternates every 8 edges, tick every 8 edges.
    sw = 8'h55;
    for (int e = 1; e <= 57; e++) begin
      clk_step();
      if (e >= 9) chk($sformatf("blink_tick_e%0d", e), {7'b0, step_tick},
                      {7'b0, (e >= 15 && (e - 15) % 8 == 0)});
      if (e >= 9 && (e - 9) % 8 == 0)
        chk($sformatf("blink_led_e%0d", e), led, (((e - 9) / 8) % 2 == 0) ? 8'h15 : 8'h00);
    end

    // CHASE including the 80 -> 01 wrap.
    sw = 8'h80;
    for (int e = 1; e <= 9 + 8 * 9; e++) begin
      clk_step();
      if (e >= 9 && (e - 9) % 8 == 0)
        chk($sformatf("chase_j%0d", (e - 9) / 8), led, one << (((e - 9) / 8) % 8));
    end

    // COUNT through a full wrap.
    sw = 8'hC0;
    for (int e = 1; e <= 9 + 8 * 257; e++) begin
      clk_step();
      if (e >= 9 && (e - 9) % 8 == 0)
        chk($sformatf("count_j%0d", (e - 9) / 8), led, 8'(((e - 9) / 8) % 256));
    end

    // Switch COUNT -> CHASE mid-count; timer restarts at the mode change.
    repeat (3) clk_step();
    sw = 8'h80;
    for (int e = 1; e <= 17; e++) begin
      clk_step();
      if (e == 8) chk("sw_mode", {6'b0, mode}, 8'h02);
      if (e == 9) chk("sw_led", led, 8'h01);
      if (e >= 8 && e <= 14) chk($sformatf("sw_notick_e%0d", e), {7'b0, step_tick}, 8'h00);
      if (e == 15) chk("sw_first_tick", {7'b0, step_tick}, 8'h01);
      if (e == 17) chk("sw_led_adv", led, 8'h02);
    end

    // Mode change landing on the same edge as a step tick.
    t = 0;
    while (step_tick !== 1'b1 && t < 20) begin clk_step(); t++; end
    chk("coin_found_tick", {7'b0, step_tick}, 8'h01);
    clk_step();
    sw = 8'hC0;
    repeat (7) clk_step();
    chk("coin_pre_tick", {7'b0, step_tick}, 8'h01);
    clk_step();
    chk("coin_mode", {6'b0, mode}, 8'h03);
    chk("coin_tick", {7'b0, step_tick}, 8'h00);
    clk_step();
    chk("coin_led", led, 8'h00);

    // Randomized switch activity against the model, with one async reset.
    for (int s = 0; s < 300; s++) begin
      sw = 8'($urandom);
      if (s == 150) do_reset();
      repeat ($urandom_range(1, 30)) clk_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
